// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and defaults for the async FIFO read side.
// Widths here track the FIFO instance defaults.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int PK_NBYTES  = 4;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_EMIT = 2'd2
  } pk_state_e;

endpackage

// File: rtl/fifo_rd_packer_pack_acc.sv
// pack_acc: byte-slot assembly buffer with fill count.
// word_o merges the byte arriving this cycle into its slot.
module pack_acc
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int NBYTES = PK_NBYTES,
  localparam int CW    = $clog2(NBYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    wr_i,
  input  logic [WIDTH-1:0]        din_i,
  output logic [CW-1:0]           cnt_o,
  output logic [WIDTH*NBYTES-1:0] word_o
);

  logic [NBYTES-1:0][WIDTH-1:0] slot_q;
  logic [CW-1:0]                cnt_q;

  // Slots clear wholesale so unfilled bytes always read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      slot_q <= '0;
      cnt_q  <= '0;
    end else if (wr_i && cnt_q < CW'(NBYTES)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (cnt_q == CW'(i)) slot_q[i] <= din_i;
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Current contents plus the byte landing this cycle
  always_comb begin
    word_o = slot_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_i && cnt_q == CW'(i)) begin
        word_o[i*WIDTH +: WIDTH] = din_i;
      end
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops FIFO bytes, packs them little-endian into
// words on a valid/ready stream; flush emits a partial last word.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int NBYTES = PK_NBYTES
) (
  input  logic                    rd_clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_EN,
  input  logic [WIDTH-1:0]        fifo_data_out,
  input  logic                    fifo_Dout_valid,
  input  logic                    flush,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH*NBYTES-1:0] m_data,
  output logic [NBYTES-1:0]       m_keep,
  output logic                    m_last,
  output logic                    busy,
  output logic                    err_unexp
);

  localparam int CW = $clog2(NBYTES + 1);
  localparam int DW = WIDTH * NBYTES;
  localparam logic [CW:0] NB = (CW+1)'(NBYTES);

  pk_state_e         state_q;
  logic              inflight_q;
  logic              err_q;
  logic              valid_q;
  logic              last_q;
  logic [DW-1:0]     data_q;
  logic [NBYTES-1:0] keep_q;

  logic [CW-1:0]     cnt;
  logic [DW-1:0]     word;
  logic [NBYTES-1:0] part_keep;
  logic [CW:0]       cnt_v;
  logic [CW:0]       cnt_f;
  logic              v;
  logic              out_free;
  logic              loading;
  logic              emit;
  logic              flush_last;

  // Bytes with no pop in flight are discarded
  assign v        = fifo_Dout_valid & inflight_q;
  assign out_free = ~valid_q | m_ready;
  assign cnt_v    = {1'b0, cnt} + {{CW{1'b0}}, v};
  assign cnt_f    = {1'b0, cnt} + {{CW{1'b0}}, inflight_q};
  assign loading  = (cnt_v == NB) & out_free;
  assign emit     = (state_q == FLUSH_EMIT) & out_free;

  assign flush_last = flush | (state_q != FILL);

  assign fifo_rd_EN = rst_n & ~fifo_empty & ~flush
                    & (state_q == FILL)
                    & (loading | (cnt_f < NB));

  // Partial-word keep mask, contiguous from bit 0
  always_comb begin
    part_keep = '0;
    for (int i = 0; i < NBYTES; i++) begin
      part_keep[i] = (CW'(i) < cnt);
    end
  end

  pack_acc #(
    .WIDTH  (WIDTH),
    .NBYTES (NBYTES)
  ) u_acc (
    .clk    (rd_clk),
    .rst_n  (rst_n),
    .clr_i  (loading | emit),
    .wr_i   (v),
    .din_i  (fifo_data_out),
    .cnt_o  (cnt),
    .word_o (word)
  );

  // Track outstanding pop and latch stray read-valid pulses
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_EN & ~fifo_empty;
      if (fifo_Dout_valid & ~inflight_q) err_q <= 1'b1;
    end
  end

  // Flush FSM and output word register
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      if (loading) begin
        valid_q <= 1'b1;
        data_q  <= word;
        keep_q  <= '1;
        last_q  <= flush_last;
      end else if (emit) begin
        valid_q <= 1'b1;
        data_q  <= word;
        keep_q  <= part_keep;
        last_q  <= 1'b1;
      end else if (m_ready) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        FILL: begin
          if (flush) state_q <= FLUSH_WAIT;
        end
        FLUSH_WAIT: begin
          if (!inflight_q) begin
            if (cnt == '0) begin
              state_q <= FILL;
            end else if (cnt != CW'(NBYTES)) begin
              state_q <= FLUSH_EMIT;
            end else if (loading) begin
              state_q <= FILL;
            end
          end
        end
        FLUSH_EMIT: begin
          if (out_free) state_q <= FILL;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign m_valid   = valid_q;
  assign m_data    = data_q;
  assign m_keep    = keep_q;
  assign m_last    = last_q;
  assign err_unexp = err_q;
  assign busy      = (cnt != '0) | inflight_q
                   | (state_q != FILL) | valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed bench with a behavioural FIFO read port.
// Outputs are sampled on the falling edge, inputs driven after rise.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_rd_EN;
  logic [7:0]  fifo_data_out;
  logic        fifo_Dout_valid;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        busy;
  logic        err_unexp;

  always #5 clk = ~clk;

  fifo_rd_packer #(
    .WIDTH  (8),
    .NBYTES (4)
  ) dut (
    .rd_clk          (clk),
    .rst_n           (rst_n),
    .fifo_empty      (fifo_empty),
    .fifo_rd_EN      (fifo_rd_EN),
    .fifo_data_out   (fifo_data_out),
    .fifo_Dout_valid (fifo_Dout_valid),
    .flush           (flush),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_keep          (m_keep),
    .m_last          (m_last),
    .busy            (busy),
    .err_unexp       (err_unexp)
  );

  logic [7:0]  fq [$];
  logic [31:0] wd [$];
  logic [3:0]  wk [$];
  logic        wl [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int en_cnt, en_first, en_last, v_first;
  logic force_dv = 1'b0;

  logic        s_en, s_valid, s_busy, s_err;
  logic [31:0] s_data;

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic clr_log();
    wd.delete();
    wk.delete();
    wl.delete();
    en_cnt   = 0;
    en_first = -1;
    en_last  = -1;
    v_first  = -1;
  endtask

  task automatic tick();
    logic take;
    @(negedge clk);
    cyc++;
    s_en    = fifo_rd_EN;
    s_valid = m_valid;
    s_data  = m_data;
    s_busy  = busy;
    s_err   = err_unexp;
    take    = fifo_rd_EN && !fifo_empty;
    if (take) begin
      en_cnt++;
      if (en_first < 0) en_first = cyc;
      en_last = cyc;
    end
    if (m_valid && v_first < 0) v_first = cyc;
    if (m_valid && m_ready) begin
      wd.push_back(m_data);
      wk.push_back(m_keep);
      wl.push_back(m_last);
    end
    @(posedge clk);
    #1;
    fifo_Dout_valid = force_dv;
    if (take) begin
      fifo_data_out   = fq.pop_front();
      fifo_Dout_valid = 1'b1;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    fifo_empty      = 1'b0;
    fifo_data_out   = '0;
    fifo_Dout_valid = 1'b0;
    flush           = 1'b0;
    m_ready         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({fifo_rd_EN, m_valid, m_last, busy, err_unexp} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000",
        {fifo_rd_EN, m_valid, m_last, busy, err_unexp});
    end
    n_cmp++;
    if ({m_data, m_keep} !== 36'h0) begin
      n_bad++;
      $display("FAIL reset_word: got %h/%h want 0/0", m_data, m_keep);
    end
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_word();
    clr_log();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (10) tick();
    n_cmp++;
    if (wd.size() != 1) begin
      n_bad++;
      $display("FAIL single_cnt: got %0d words want 1", wd.size());
    end
    n_cmp++;
    if (wd.size() < 1 || wd[0] !== 32'h44332211 ||
        wk[0] !== 4'hF || wl[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_word: got %h/%h/%b want 44332211/f/0",
        wd[0], wk[0], wl[0]);
    end
    n_cmp++;
    if (v_first - en_first != 5) begin
      n_bad++;
      $display("FAIL latency: got %0d want 5", v_first - en_first);
    end
    n_cmp++;
    if (s_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_busy: got %b want 0", s_busy);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ed [3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    clr_log();
    for (int i = 1; i <= 12; i++) push(8'(i));
    repeat (20) tick();
    n_cmp++;
    if (en_cnt != 12 || en_last - en_first + 1 != 12) begin
      n_bad++;
      $display("FAIL stream_pops: got %0d pops over %0d cycles want 12/12",
        en_cnt, en_last - en_first + 1);
    end
    n_cmp++;
    if (wd.size() != 3) begin
      n_bad++;
      $display("FAIL stream_cnt: got %0d words want 3", wd.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= wd.size() || wd[i] !== ed[i] ||
          wk[i] !== 4'hF || wl[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL stream_w%0d: got %h/%h/%b want %h/f/0",
          i, wd[i], wk[i], wl[i], ed[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed [3] = '{32'hA3A2A1A0, 32'hA7A6A5A4, 32'h0000A9A8};
    logic [3:0]  ek [3] = '{4'hF, 4'hF, 4'h3};
    logic        el [3] = '{1'b0, 1'b0, 1'b1};
    int hold_bad = 0;
    clr_log();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
    repeat (16) begin
      tick();
      if (s_valid && s_data !== 32'hA3A2A1A0) hold_bad++;
    end
    n_cmp++;
    if (en_cnt != 8) begin
      n_bad++;
      $display("FAIL bp_pops: got %0d want 8", en_cnt);
    end
    n_cmp++;
    if (s_en !== 1'b0 || s_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_stall: got en=%b valid=%b want en=0 valid=1",
        s_en, s_valid);
    end
    n_cmp++;
    if (hold_bad != 0) begin
      n_bad++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_bad);
    end
    m_ready = 1'b1;
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if (wd.size() != 3) begin
      n_bad++;
      $display("FAIL bp_cnt: got %0d words want 3", wd.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= wd.size() || wd[i] !== ed[i] ||
          wk[i] !== ek[i] || wl[i] !== el[i]) begin
        n_bad++;
        $display("FAIL bp_w%0d: got %h/%h/%b want %h/%h/%b",
          i, wd[i], wk[i], wl[i], ed[i], ek[i], el[i]);
      end
    end
  endtask

  task automatic test_flush_partial();
    clr_log();
    push(8'h55); push(8'h66);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if (wd.size() != 1 || wd[0] !== 32'h00006655 ||
        wk[0] !== 4'b0011 || wl[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_part: got n=%0d %h/%h/%b want 1 00006655/3/1",
        wd.size(), wd[0], wk[0], wl[0]);
    end
    clr_log();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if (wd.size() != 0 || v_first >= 0) begin
      n_bad++;
      $display("FAIL flush_empty: got %0d words want 0", wd.size());
    end
    n_cmp++;
    if (s_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_idle: got busy=%b want 0", s_busy);
    end
  endtask

  task automatic test_flush_coincident();
    clr_log();
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (8) tick();
    n_cmp++;
    if (wd.size() != 1) begin
      n_bad++;
      $display("FAIL flush_co_cnt: got %0d words want 1", wd.size());
    end
    n_cmp++;
    if (wd.size() < 1 || wd[0] !== 32'hC4C3C2C1 ||
        wk[0] !== 4'hF || wl[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_co_word: got %h/%h/%b want c4c3c2c1/f/1",
        wd[0], wk[0], wl[0]);
    end
  endtask

  task automatic test_err_and_reset();
    clr_log();
    force_dv = 1'b1;
    tick();
    force_dv = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (s_err !== 1'b1 || s_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL err_set: got err=%b busy=%b want 1/0", s_err, s_busy);
    end
    repeat (4) tick();
    n_cmp++;
    if (s_err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b want 1", s_err);
    end
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hE0 + 8'(i));
    repeat (5) tick();
    n_cmp++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_rst: got valid=%b busy=%b want 1/1",
        m_valid, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({fifo_rd_EN, m_valid, m_last, busy, err_unexp} !== 5'b0) begin
      n_bad++;
      $display("FAIL async_rst_flags: got %b want 00000",
        {fifo_rd_EN, m_valid, m_last, busy, err_unexp});
    end
    n_cmp++;
    if ({m_data, m_keep} !== 36'h0) begin
      n_bad++;
      $display("FAIL async_rst_word: got %h/%h want 0/0", m_data, m_keep);
    end
    fq.delete();
    fifo_empty = 1'b1;
    m_ready = 1'b1;
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (s_err !== 1'b1 || s_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_late_data: got err=%b valid=%b want 1/0",
        s_err, s_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stream();
    test_backpressure();
    test_flush_partial();
    test_flush_coincident();
    test_err_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain. It pops bytes from the FIFO read port, accounting for the FIFO's one-cycle read latency, and packs them little-endian into NBYTES-wide words. Words leave on a valid/ready stream toward downstream logic. A flush request emits a partial word with byte-keep and a last marker.

## Interface
- WIDTH, 8, byte width; must match the FIFO WIDTH
- NBYTES, 4, bytes per output word (≥2)
- rd_clk  in  1  clock (the FIFO read clock)
- rst_n  in  1  asynchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag, rd_clk domain
- fifo_rd_EN  out  1  pop request; FIFO samples it at posedge rd_clk
- fifo_data_out  in  WIDTH  FIFO read data
- fifo_Dout_valid  in  1  fifo_data_out valid; one rd_clk after an accepted pop, one-cycle pulse
- flush  in  1  one-cycle request to emit the current partial word
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  WIDTH*NBYTES  packed word; first byte popped sits in [WIDTH-1:0]
- m_keep  out  NBYTES  per-byte valid, contiguous from bit 0
- m_last  out  1  word produced by a flush
- busy  out  1  cnt≠0, read in flight, flush in progress, or m_valid
- err_unexp  out  1  sticky: fifo_Dout_valid seen with no pop in flight

## Operation
- State
  - acc: NBYTES×WIDTH assembly buffer
  - cnt: 0..NBYTES bytes held
  - inflight: 1 bit = registered (fifo_rd_EN & ~fifo_empty)
  - output register: m_data, m_keep, m_last, m_valid
- Capture: on fifo_Dout_valid, byte goes to acc slot cnt; cnt += 1.
- out_free = ~m_valid | m_ready.
- loading = (cnt + fifo_Dout_valid == NBYTES) & out_free.
  - When loading, the word is built from acc plus the arriving byte and loaded straight into the output register.
  - m_keep = all ones; m_last = 0; cnt → 0.
- Word complete but ~out_free: cnt holds at NBYTES and no pops are issued until the word loads.
- fifo_rd_EN, combinational from registered state, fifo_empty and m_ready:
  - fifo_rd_EN = ~fifo_empty & (state==FILL) & ~flush & (loading | cnt+inflight < NBYTES).
- FSM
  - FILL: normal packing.
    - flush=1 → FLUSH_WAIT. No pop is issued in the flush cycle.
  - FLUSH_WAIT: no pops; waits for inflight=0. Then:
    - cnt==0 → FILL; nothing emitted.
    - cnt==NBYTES → full word handled by the normal load path (m_last=1); then FILL.
    - else → FLUSH_EMIT.
  - FLUSH_EMIT: when out_free, load acc with m_keep = (1<<cnt)-1 and m_last=1; unused bytes are zero; cnt → 0; then FILL.
- flush while in FLUSH_WAIT or FLUSH_EMIT is ignored.
- err_unexp sets when fifo_Dout_valid=1 & inflight=0; clears only on reset. The unexpected byte is discarded.

## Timing
- Reset values: fifo_rd_EN 0, m_valid 0, m_data 0, m_keep 0, m_last 0, busy 0, err_unexp 0; cnt 0; inflight 0; state FILL.
- Reset mid-word: partial data is lost. Any FIFO data returning after release counts as unexpected, so err_unexp sets.
- Latency: first pop in cycle N → m_valid high in cycle N+NBYTES+1 with continuous non-empty FIFO.
- Throughput: one byte per cycle sustained while m_ready=1.
- m_data, m_keep and m_last hold stable while m_valid & ~m_ready.
- Handshake: a transfer completes on m_valid & m_ready at the edge. With loading in the same cycle, the next word replaces it back-to-back with no bubble.
- Flush latency: at most 2 cycles to m_valid when out_free (one cycle for in-flight data, one to load).
- fifo_empty rising while fifo_rd_EN=1: the FIFO ignores the pop, inflight is not set, and the count stays correct.

## Structure
- Shared package fifo_pkg:
  - state enum (FILL, FLUSH_WAIT, FLUSH_EMIT)
  - default WIDTH/NBYTES localparams, matching the FIFO defaults (8/8 depth)
- One natural sub-module: pack_acc, the byte-slot register file with cnt and build-word output. Issue logic and FSM stay in the top.

## Test plan
- Write 0x11,0x22,0x33,0x44 through the FIFO, m_ready=1 → one word m_data=0x44332211, m_keep=4'hF, m_last=0.
- Stream 12 bytes 0x01..0x0C, m_ready=1 → words 0x04030201, 0x08070605, 0x0C0B0A09 with no gaps between bytes on fifo_rd_EN.
- 6 bytes 0xA0..0xA5 with m_ready=0 → first word held stable and pops stop after 4+4 bytes are buffered or the FIFO empties; m_ready=1 → words in order with no loss.
- Bytes 0x55,0x66, then flush pulse → m_data=0x00006655, m_keep=4'b0011, m_last=1; after this flush, with no data in flight, a second flush emits nothing.
- Flush in the same cycle that the 4th byte's Dout_valid arrives → full word with m_keep=4'hF, m_last=1; no extra partial word.
- Force fifo_Dout_valid=1 with no pop → err_unexp=1, stays set until rst_n low; reset mid-word → all outputs return to reset values asynchronously.
